fibo_datapath: RTL and testbench

Execution end of the Fibonacci calculator, driven by fibo_fsm's command outputs (alu_opcode, rd_addr1/2, wrt_addr, wrt_en, load_data).
- Holds a 4-entry register file with an ALU and a write-back path.
- Returns ZERO_FLAG to the controller.
- Exposes the result and a sticky overflow indication to the top level.

---
 rtl/fibo_pkg.sv | 23 ++
 rtl/fibo_alu.sv | 36 +++
 rtl/fibo_datapath.sv | 83 ++++++++
 tb/tb_fibo_datapath.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fibo_pkg.sv
// rtl/fibo_pkg.sv - shared sizes, ALU opcodes and register roles for the Fibonacci calculator
package fibo_pkg;

    localparam int FIBO_SIZE   = 4;
    localparam int FIBO_DATA_W = 8;

    typedef enum logic [2:0] {
        OP_PASS = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_DEC  = 3'b011,
        OP_INC  = 3'b100,
        OP_AND  = 3'b101,
        OP_OR   = 3'b110,
        OP_CLR  = 3'b111
    } opcode_e;

    localparam logic [1:0] REG_CNT  = 2'd0;
    localparam logic [1:0] REG_PREV = 2'd1;
    localparam logic [1:0] REG_CUR  = 2'd2;
    localparam logic [1:0] REG_TMP  = 2'd3;

endpackage

// File: rtl/fibo_alu.sv
// rtl/fibo_alu.sv - combinational ALU, modulo 2^DATA_W, carry-out reported for ADD only
module fibo_alu
    import fibo_pkg::*;
#(
    parameter int DATA_W = FIBO_DATA_W
) (
    input  opcode_e             op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   y,
    output logic                carry
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_PASS: y = a;
            OP_ADD: begin
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
            end
            OP_SUB:  y = a - b;
            OP_DEC:  y = a - DATA_W'(1);
            OP_INC:  y = a + DATA_W'(1);
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_CLR:  y = '0;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/fibo_datapath.sv
// rtl/fibo_datapath.sv - register file, ALU write-back, zero flag, result and sticky overflow
module fibo_datapath
    import fibo_pkg::*;
#(
    parameter int SIZE   = FIBO_SIZE,
    parameter int DATA_W = FIBO_DATA_W
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [SIZE-2:0]     alu_opcode,
    input  logic [SIZE-3:0]     rd_addr1,
    input  logic [SIZE-3:0]     rd_addr2,
    input  logic [SIZE-3:0]     wrt_addr,
    input  logic                wrt_en,
    input  logic                load_data,
    input  logic [DATA_W-1:0]   DATA_IN,
    output logic                ZERO_FLAG,
    output logic [DATA_W-1:0]   RESULT,
    output logic                OVERFLOW
);

    localparam int NREG = 2 ** (SIZE - 2);

    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] op_a, op_b, alu_y, wb_val;
    logic              alu_carry;

    // No bypass: operands come straight from the stored array.
    assign op_a = rf_q[rd_addr1];
    assign op_b = rf_q[rd_addr2];

    fibo_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (opcode_e'(alu_opcode)),
        .a     (op_a),
        .b     (op_b),
        .y     (alu_y),
        .carry (alu_carry)
    );

    assign wb_val = load_data ? DATA_IN : alu_y;

    always_comb begin
        rf_d     = rf_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (wrt_en) begin
            rf_d[wrt_addr] = wb_val;
            result_d       = wb_val;
            zero_d         = (wb_val == '0);
            // A load replaces the ALU source, so it also wins over a coincident carry.
            if (load_data)
                ovf_d = 1'b0;
            else if (alu_carry)
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            rf_q     <= rf_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign RESULT    = result_q;
    assign ZERO_FLAG = zero_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_fibo_datapath.sv
// tb/tb_fibo_datapath.sv - directed and random checks of fibo_datapath against an integer model
module tb_fibo_datapath;
    import fibo_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [2:0] alu_opcode = '0;
    logic [1:0] rd_addr1 = '0, rd_addr2 = '0, wrt_addr = '0;
    logic       wrt_en = 1'b0, load_data = 1'b0;
    logic [7:0] DATA_IN = '0;
    logic       ZERO_FLAG, OVERFLOW;
    logic [7:0] RESULT;

    fibo_datapath dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .alu_opcode (alu_opcode),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .wrt_addr   (wrt_addr),
        .wrt_en     (wrt_en),
        .load_data  (load_data),
        .DATA_IN    (DATA_IN),
        .ZERO_FLAG  (ZERO_FLAG),
        .RESULT     (RESULT),
        .OVERFLOW   (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    int m_rf [4];
    int m_res, m_zf, m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        m_res = 0;
        m_zf  = 1;
        m_ovf = 0;
    endtask

    task automatic cmd(input int op, input int r1, input int r2, input int wa,
                       input int we, input int ld, input int din);
        int a, b, alu, w, cy;
        a  = m_rf[r1];
        b  = m_rf[r2];
        cy = 0;
        case (op)
            0: alu = a;
            1: begin alu = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
            2: alu = (a - b + 256) % 256;
            3: alu = (a + 255) % 256;
            4: alu = (a + 1) % 256;
            5: alu = a & b;
            6: alu = a | b;
            default: alu = 0;
        endcase
        if (we != 0) begin
            w         = (ld != 0) ? din : alu;
            m_rf[wa]  = w;
            m_res     = w;
            m_zf      = (w == 0) ? 1 : 0;
            if (ld != 0)
                m_ovf = 0;
            else if (op == 1 && cy == 1)
                m_ovf = 1;
        end
        alu_opcode = 3'(op);
        rd_addr1   = 2'(r1);
        rd_addr2   = 2'(r2);
        wrt_addr   = 2'(wa);
        wrt_en     = 1'(we);
        load_data  = 1'(ld);
        DATA_IN    = 8'(din);
        @(posedge CLK);
        #1;
        wrt_en    = 1'b0;
        load_data = 1'b0;
        check("cmd_result", 32'(RESULT), 32'(m_res));
        check("cmd_zero", 32'(ZERO_FLAG), 32'(m_zf));
        check("cmd_ovf", 32'(OVERFLOW), 32'(m_ovf));
    endtask

    task automatic load(input int r, input int v);
        cmd(0, 0, 0, r, 1, 1, v);
    endtask

    // Rewriting a register with its own value exposes it on RESULT without disturbing it.
    task automatic peek(input int r, input int exp, input string tag);
        cmd(0, r, r, r, 1, 0, 0);
        check(tag, 32'(RESULT), 32'(exp));
    endtask

    int fib_exp [6] = '{1, 2, 3, 5, 8, 13};
    int sweep_exp [8] = '{8'hC3, 8'h1D, 8'h69, 8'hC2, 8'hC4, 8'h42, 8'hDB, 8'h00};
    int held_res, held_zf, old_r2;

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_result", 32'(RESULT), 32'd0);
        check("rst_zero", 32'(ZERO_FLAG), 32'd1);
        check("rst_ovf", 32'(OVERFLOW), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) peek(i, 0, "rst_reg");

        // Load then count down through zero
        load(REG_CNT, 2);
        check("ld2_result", 32'(RESULT), 32'd2);
        check("ld2_zero", 32'(ZERO_FLAG), 32'd0);
        cmd(OP_DEC, REG_CNT, 0, REG_CNT, 1, 0, 0);
        check("dec1_result", 32'(RESULT), 32'd1);
        cmd(OP_DEC, REG_CNT, 0, REG_CNT, 1, 0, 0);
        check("dec0_zero", 32'(ZERO_FLAG), 32'd1);
        cmd(OP_DEC, REG_CNT, 0, REG_CNT, 1, 0, 0);
        check("decwrap_result", 32'(RESULT), 32'hFF);
        check("decwrap_zero", 32'(ZERO_FLAG), 32'd0);

        // Fibonacci iterations
        load(REG_PREV, 0);
        load(REG_CUR, 1);
        for (int i = 0; i < 6; i++) begin
            cmd(OP_ADD, REG_PREV, REG_CUR, REG_TMP, 1, 0, 0);
            cmd(OP_PASS, REG_CUR, 0, REG_PREV, 1, 0, 0);
            cmd(OP_PASS, REG_TMP, 0, REG_CUR, 1, 0, 0);
            check("fib_r2", 32'(RESULT), 32'(fib_exp[i]));
            check("fib_ovf", 32'(OVERFLOW), 32'd0);
        end

        // Overflow stickiness and clear on load
        load(REG_PREV, 144);
        load(REG_CUR, 233);
        cmd(OP_ADD, REG_PREV, REG_CUR, REG_TMP, 1, 0, 0);
        check("ovf_sum", 32'(RESULT), 32'd121);
        check("ovf_set", 32'(OVERFLOW), 32'd1);
        cmd(OP_PASS, REG_TMP, 0, REG_CNT, 1, 0, 0);
        check("ovf_pass_hold", 32'(OVERFLOW), 32'd1);
        cmd(OP_DEC, REG_CNT, 0, REG_CNT, 1, 0, 0);
        check("ovf_dec_hold", 32'(OVERFLOW), 32'd1);
        load(REG_CNT, 5);
        check("ovf_load_clr", 32'(OVERFLOW), 32'd0);
        // Coincident load and carrying ADD: the load wins
        cmd(OP_ADD, REG_PREV, REG_CUR, REG_TMP, 1, 1, 7);
        check("ovf_load_wins", 32'(OVERFLOW), 32'd0);
        check("ovf_load_val", 32'(RESULT), 32'd7);

        // Hold with wrt_en low, then read-during-write
        held_res = m_res;
        held_zf  = m_zf;
        cmd(OP_ADD, REG_CUR, REG_CUR, REG_CUR, 0, 1, 9);
        check("hold_result", 32'(RESULT), 32'(held_res));
        check("hold_zero", 32'(ZERO_FLAG), 32'(held_zf));
        peek(REG_CNT, 5, "hold_r0");
        peek(REG_CUR, 233, "hold_r2");
        old_r2 = 233;
        cmd(OP_INC, REG_CUR, REG_CUR, REG_CUR, 1, 0, 0);
        check("inc_r2", 32'(RESULT), 32'(old_r2 + 1));
        peek(REG_CUR, old_r2 + 1, "inc_r2_peek");

        // Opcode sweep
        load(REG_PREV, 8'hC3);
        load(REG_CUR, 8'h5A);
        for (int op = 0; op < 8; op++) begin
            cmd(op, REG_PREV, REG_CUR, REG_TMP, 1, 0, 0);
            check("sweep", 32'(RESULT), 32'(sweep_exp[op]));
            if (op == 1) check("sweep_add_ovf", 32'(OVERFLOW), 32'd1);
            if (op == 7) check("sweep_clr_zero", 32'(ZERO_FLAG), 32'd1);
        end

        // Random commands against the model
        for (int n = 0; n < 400; n++) begin
            cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), ($urandom_range(0, 7) != 0) ? 1 : 0,
                ($urandom_range(0, 4) == 0) ? 1 : 0, int'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 4; i++) peek(i, m_rf[i], "rand_reg");

        // Asynchronous reset between edges
        load(REG_PREV, 8'hFF);
        load(REG_CUR, 8'h01);
        cmd(OP_ADD, REG_PREV, REG_CUR, REG_TMP, 1, 0, 0);
        load(REG_CNT, 8'h77);
        cmd(OP_ADD, REG_PREV, REG_CUR, REG_TMP, 1, 0, 0);
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_result", 32'(RESULT), 32'd0);
        check("arst_zero", 32'(ZERO_FLAG), 32'd1);
        check("arst_ovf", 32'(OVERFLOW), 32'd0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) peek(i, 0, "arst_reg");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
